floating_point_unit: RTL and testbench

// - Registered IEEE-754 binary16 (FP16) adder/subtractor for the TPU datapath.
// - Computes a+b or a-b each enabled cycle and presents the result one clock later.
// - Serves as the accumulate stage behind the multiply array; purely combinational core plus one output register.

---
 rtl/floating_point_unit.sv | 142 ++++++++++++++
 tb/tb_floating_point_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_unit.sv
// Registered FP16 (binary16) adder/subtractor: result <= a +/- b on each enabled clock edge.
// Define FPU_DENORM_EN for gradual underflow; otherwise subnormal inputs and results flush to signed zero.
module floating_point_unit #(
  parameter int DATA_WIDTH = 16  // only 16 is supported: 1 sign, 5 exponent (bias 15), 10 fraction
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dec,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [14:0] INF_MAG = 15'h7C00;

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) n = 4'(13 - i);
    end
    return n;
  endfunction

  logic        sa, sb;
  logic [4:0]  ea, eb, ea_adj, eb_adj;
  logic [9:0]  fa, fb;
  logic [10:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa     = a[15];
  assign sb     = b[15] ^ dec;
  assign ea     = a[14:10];
  assign eb     = b[14:10];
  assign fa     = a[9:0];
  assign fb     = b[9:0];
  assign a_nan  = (ea == 5'h1f) && (fa != 10'd0);
  assign b_nan  = (eb == 5'h1f) && (fb != 10'd0);
  assign a_inf  = (ea == 5'h1f) && (fa == 10'd0);
  assign b_inf  = (eb == 5'h1f) && (fb == 10'd0);
`ifdef FPU_DENORM_EN
  assign a_zero = (ea == 5'd0) && (fa == 10'd0);
  assign b_zero = (eb == 5'd0) && (fb == 10'd0);
`else
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
`endif
  // Subnormals carry an implicit 0 and share the exponent of 1 with the smallest normals.
  assign ea_adj = (ea == 5'd0) ? 5'd1 : ea;
  assign eb_adj = (eb == 5'd0) ? 5'd1 : eb;
  assign ma     = {ea != 5'd0, fa};
  assign mb     = {eb != 5'd0, fb};

  logic        a_ge, sx, eff_sub, underflow, round_up;
  logic [4:0]  ex, ey, shift, norm_sh, exp_field;
  logic [10:0] mx, my;
  logic [26:0] y_full;
  logic [13:0] x_al, y_al, norm;
  logic [14:0] sum;
  logic [3:0]  lz;
  logic [6:0]  e_n, e_r;
  logic [11:0] mant_r;
  logic [9:0]  frac_r;
  logic [15:0] core_res;

  // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
  always_comb begin
    norm_sh   = 5'd0;
    underflow = 1'b0;
    e_n       = 7'd0;
    norm      = 14'd0;

    a_ge    = a[14:0] >= b[14:0];
    sx      = a_ge ? sa : sb;
    ex      = a_ge ? ea_adj : eb_adj;
    ey      = a_ge ? eb_adj : ea_adj;
    mx      = a_ge ? ma : mb;
    my      = a_ge ? mb : ma;
    eff_sub = sa ^ sb;

    // Mantissas carry three extra low bits: guard, round, sticky.
    shift  = ex - ey;
    x_al   = {mx, 3'b000};
    y_full = {my, 16'd0} >> shift;
    if (shift >= 5'd13) y_al = {13'd0, 1'b1};
    else                y_al = {y_full[26:14], |y_full[13:0]};

    sum = eff_sub ? ({1'b0, x_al} - {1'b0, y_al}) : ({1'b0, x_al} + {1'b0, y_al});
    lz  = lzc14(sum[13:0]);

    if (sum[14]) begin
      norm = {sum[14:2], sum[1] | sum[0]};
      e_n  = {2'b00, ex} + 7'd1;
    end else begin
      if ({1'b0, lz} >= ex) begin
`ifdef FPU_DENORM_EN
        norm_sh = ex - 5'd1;
`else
        underflow = 1'b1;
`endif
        e_n = 7'd1;
      end else begin
        norm_sh = {1'b0, lz};
        e_n     = {2'b00, ex} - {3'b000, lz};
      end
      norm = sum[13:0] << norm_sh;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[13:3]} + {11'd0, round_up};
    if (mant_r[11]) begin
      e_r    = e_n + 7'd1;
      frac_r = mant_r[10:1];
    end else begin
      e_r    = e_n;
      frac_r = mant_r[9:0];
    end
    // A result without the hidden bit is subnormal and encodes exponent field 0.
    exp_field = (mant_r[11] | mant_r[10]) ? e_r[4:0] : 5'd0;

    if (a_nan || b_nan)        core_res = QNAN;
    else if (a_inf && b_inf)   core_res = (sa == sb) ? {sa, INF_MAG} : QNAN;
    else if (a_inf)            core_res = {sa, INF_MAG};
    else if (b_inf)            core_res = {sb, INF_MAG};
    else if (a_zero && b_zero) core_res = {sa & sb, 15'd0};
    else if (a_zero)           core_res = {sb, b[14:0]};
    else if (b_zero)           core_res = a;
    else if (sum == 15'd0)     core_res = 16'h0000;
    else if (underflow)        core_res = {sx, 15'd0};
    else if (e_r >= 7'd31)     core_res = {sx, INF_MAG};
    else                       core_res = {sx, exp_field, frac_r};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  result <= 16'h0000;
    else if (en) result <= core_res;
  end

endmodule

// File: tb/tb_floating_point_unit.sv
// Self-checking bench for floating_point_unit: directed cases plus random traffic
// compared against an exact-integer FP16 reference model.
module tb_floating_point_unit;

  logic        clk = 1'b0;
  logic        reset, en, dec;
  logic [15:0] a, b, result;
  int          checks = 0;
  int          passes = 0;

  floating_point_unit #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .dec(dec), .a(a), .b(b), .result(result)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: exact values scaled by 2^24 ----------------
  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction

  function automatic bit is_inf(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] == 10'd0);
  endfunction

  function automatic longint fp_mag(input logic [15:0] v);
    longint f;
    f = longint'(v[9:0]);
    if (v[14:10] == 5'd0) begin
`ifdef FPU_DENORM_EN
      return f;
`else
      return 0;
`endif
    end
    return (1024 + f) << (int'(v[14:10]) - 1);
  endfunction

  function automatic logic [15:0] fp_round(input logic s, input longint mag);
    int     p, e, sh;
    longint q, rem, half;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    e = p - 9;
    if (e < 1) begin
`ifdef FPU_DENORM_EN
      return {s, 5'd0, 10'(mag)};
`else
      return {s, 15'd0};
`endif
    end
    sh = p - 10;
    q  = mag >> sh;
    if (sh > 0) begin
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00};
    return {s, 5'(e), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic d);
    logic   sy;
    longint vx, vy, s;
    sy = y[15] ^ d;
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if (is_inf(x) && is_inf(y)) return (x[15] == sy) ? {x[15], 15'h7C00} : 16'h7E00;
    if (is_inf(x)) return x;
    if (is_inf(y)) return {sy, 15'h7C00};
    vx = x[15] ? -fp_mag(x) : fp_mag(x);
    vy = sy    ? -fp_mag(y) : fp_mag(y);
    if (vx == 0 && vy == 0) return {x[15] & sy, 15'd0};
    s = vx + vy;
    if (s == 0) return 16'h0000;
    return fp_round(s < 0, (s < 0) ? -s : s);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic d, input logic e);
    @(negedge clk);
    a = x; b = y; dec = d; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic gen(output logic [15:0] x, output logic [15:0] y);
    logic [4:0] e;
    x = 16'($urandom);
    case ($urandom_range(0, 3))
      0: y = 16'($urandom);
      1: begin
        e = x[14:10] + 5'($urandom_range(0, 4)) - 5'd2;
        y = {1'($urandom), e, 10'($urandom)};
      end
      2: y = {~x[15], x[14:0]} ^ 16'($urandom_range(0, 15));
      default: begin
        x[14:10] = 5'($urandom_range(0, 3));
        y = {1'($urandom), 5'($urandom_range(0, 3)), 10'($urandom)};
      end
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; en = 1'b1; dec = 1'b0; a = 16'h4000; b = 16'h4200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== 16'h0000) $display("FAIL reset_hold cycle %0d: got %h want 0000", i, result);
      else passes++;
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (result !== 16'h4500) $display("FAIL reset_release: got %h want 4500", result);
    else passes++;
  endtask

  task automatic test_async_reset();
    drive(16'h3800, 16'h3800, 1'b0, 1'b1);
    checks++;
    if (result !== 16'h3C00) $display("FAIL async_pre: got %h want 3C00", result);
    else passes++;
    @(negedge clk); reset = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000) $display("FAIL async_reset: got %h want 0000", result);
    else passes++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va[$], vb[$], vr[$];
    logic        vd[$];
    logic [15:0] tiny;
`ifdef FPU_DENORM_EN
    tiny = 16'h0001;
`else
    tiny = 16'h0000;
`endif
    va = '{16'h4000, 16'hC100, 16'h3800, 16'h3E00, 16'hBC00, 16'h0000, 16'h4400, 16'h3C00,
           16'h7C00, 16'h7C00, 16'h7E01, 16'h7BFF, 16'h0000, 16'h8000, 16'h8000, 16'h0000,
           16'h7BFF, 16'h3C00, 16'h3C01, 16'h0401, 16'h3C00, 16'hFC00};
    vb = '{16'h4200, 16'h4400, 16'h3800, 16'hBE00, 16'hBC00, 16'h4200, 16'h3C00, 16'h3C00,
           16'h3C00, 16'hFC00, 16'h3C00, 16'h7BFF, 16'h0000, 16'h8000, 16'h0000, 16'h4200,
           16'h3C00, 16'h1000, 16'h1000, 16'h0400, 16'h7C00, 16'h7C00};
    vd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vr = '{16'h4500, 16'h3E00, 16'h3C00, 16'h0000, 16'hC000, 16'h4200, 16'h4200, 16'h0000,
           16'h7C00, 16'h7E00, 16'h7E00, 16'h7C00, 16'h0000, 16'h8000, 16'h0000, 16'hC200,
           16'h7BFF, 16'h3C00, 16'h3C02, tiny,     16'hFC00, 16'hFC00};
    for (int i = 0; i < va.size(); i++) begin
      drive(va[i], vb[i], vd[i], 1'b1);
      checks++;
      if (result !== vr[i])
        $display("FAIL directed[%0d] %h %s %h: got %h want %h", i, va[i], vd[i] ? "-" : "+", vb[i], result, vr[i]);
      else passes++;
    end
  endtask

  task automatic test_hold();
    drive(16'h4000, 16'h4200, 1'b0, 1'b1);
    checks++;
    if (result !== 16'h4500) $display("FAIL hold_setup: got %h want 4500", result);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      drive(16'h3800, 16'h3800, 1'b0, 1'b0);
      checks++;
      if (result !== 16'h4500) $display("FAIL hold cycle %0d: got %h want 4500", i, result);
      else passes++;
    end
  endtask

  task automatic test_random_back_to_back();
    logic [15:0] x, y, want;
    logic        d;
    for (int i = 0; i < 400; i++) begin
      gen(x, y);
      d = 1'($urandom);
      want = ref_add(x, y, d);
      drive(x, y, d, 1'b1);
      checks++;
      if (result !== want)
        $display("FAIL random[%0d] %h %s %h: got %h want %h", i, x, d ? "-" : "+", y, result, want);
      else passes++;
    end
  endtask

  task automatic test_random_enable();
    logic [15:0] x, y, want;
    logic        d, e;
    want = result;
    for (int i = 0; i < 200; i++) begin
      gen(x, y);
      d = 1'($urandom);
      e = 1'($urandom);
      if (e) want = ref_add(x, y, d);
      drive(x, y, d, e);
      checks++;
      if (result !== want)
        $display("FAIL rand_en[%0d] en=%b %h %s %h: got %h want %h", i, e, x, d ? "-" : "+", y, result, want);
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; dec = 1'b0; a = 16'h0000; b = 16'h0000;
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_random_back_to_back();
    test_random_enable();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
